// File: rtl/soc_system_dsp_byte_arbiter.sv
// Round-robin arbiter sharing the DSP byte PIO between fabric requesters.
// Each grant writes one byte, reads it back, acks, then dwells.
module soc_system_dsp_byte_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 ack_err,
  output logic                 busy,
  output logic [2:0]           owner,
  output logic                 err_sticky,
  input  logic                 err_clear,
  output logic [15:0]          write_count,
  output logic [1:0]           avm_address,
  output logic                 avm_chipselect,
  output logic                 avm_write_n,
  output logic [31:0]          avm_writedata,
  input  logic [31:0]          avm_readdata
);
  localparam int IW = $clog2(NUM_REQ);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WRITE  = 3'd1;
  localparam logic [2:0] S_VERIFY = 3'd2;
  localparam logic [2:0] S_ACK    = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;

  localparam logic [7:0] HOLD_INIT =
    (HOLD_CYCLES > 0) ? 8'(HOLD_CYCLES - 1) : 8'd0;
  localparam logic [IW-1:0] LAST_INIT = IW'(NUM_REQ - 1);

  logic [2:0]         r_state;
  logic [2:0]         w_state_n;
  logic [IW-1:0]      r_last;
  logic [IW-1:0]      w_win;
  logic               w_found;
  logic [7:0]         w_bytes [NUM_REQ];
  logic [7:0]         r_byte;
  logic [7:0]         r_hold;
  logic               r_mis;
  logic               w_mis;
  logic [NUM_REQ-1:0] r_ack;
  logic               r_ack_err;
  logic               r_busy;
  logic               r_sticky;
  logic               r_cs;
  logic               r_wn;
  logic [2:0]         r_owner;
  logic [15:0]        r_write_count;
  logic [31:0]        r_wd;
  logic               w_unused;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign w_bytes[g] = req_data[8*g +: 8];
  end

  function automatic logic [IW-1:0] rr_idx(
    input logic [IW-1:0] base,
    input int            off
  );
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s -= NUM_REQ;
    return IW'(s);
  endfunction

  // Search upward from the slot after the last grant.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_last;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_found && req[rr_idx(r_last, k)]) begin
        w_found = 1'b1;
        w_win   = rr_idx(r_last, k);
      end
    end
  end

  assign w_mis    = (avm_readdata[7:0] != r_byte);
  assign w_unused = ^avm_readdata[31:8];

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE:   if (w_found) w_state_n = S_WRITE;
      S_WRITE:  w_state_n = S_VERIFY;
      S_VERIFY: w_state_n = S_ACK;
      S_ACK:    w_state_n = (HOLD_CYCLES > 0) ? S_HOLD : S_IDLE;
      S_HOLD:   if (r_hold == 8'd0) w_state_n = S_IDLE;
      default:  w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_last        <= LAST_INIT;
      r_byte        <= 8'd0;
      r_hold        <= 8'd0;
      r_mis         <= 1'b0;
      r_ack         <= '0;
      r_ack_err     <= 1'b0;
      r_busy        <= 1'b0;
      r_sticky      <= 1'b0;
      r_cs          <= 1'b0;
      r_wn          <= 1'b1;
      r_owner       <= 3'd0;
      r_write_count <= 16'd0;
      r_wd          <= 32'd0;
    end else begin
      r_state   <= w_state_n;
      r_busy    <= (w_state_n != S_IDLE);
      r_ack     <= '0;
      r_ack_err <= 1'b0;
      if (err_clear) r_sticky <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_last  <= w_win;
            r_owner <= 3'(w_win);
            r_byte  <= w_bytes[w_win];
            r_cs    <= 1'b1;
            r_wn    <= 1'b0;
            r_wd    <= {24'd0, w_bytes[w_win]};
          end
        end
        S_WRITE: r_wn <= 1'b1;
        S_VERIFY: begin
          r_mis         <= w_mis;
          r_ack         <= NUM_REQ'(1) << r_last;
          r_ack_err     <= w_mis;
          r_write_count <= r_write_count + 16'd1;
          if (w_mis) r_sticky <= 1'b1;
          r_cs          <= 1'b0;
          r_wd          <= 32'd0;
        end
        // Re-assert so a clear overlapping the ack cycle cannot hide it.
        S_ACK: begin
          if (r_mis) r_sticky <= 1'b1;
          r_hold <= HOLD_INIT;
        end
        S_HOLD: r_hold <= r_hold - 8'd1;
        default: ;
      endcase
    end
  end

  assign ack            = r_ack;
  assign ack_err        = r_ack_err;
  assign busy           = r_busy;
  assign owner          = r_owner;
  assign err_sticky     = r_sticky;
  assign write_count    = r_write_count;
  assign avm_address    = 2'd0;
  assign avm_chipselect = r_cs;
  assign avm_write_n    = r_wn;
  assign avm_writedata  = r_wd;

endmodule

// File: tb/tb_soc_system_dsp_byte_arbiter.sv
// Bench for soc_system_dsp_byte_arbiter: PIO model plus
// round-robin reference, with a second instance for dwell timing.
module tb_soc_system_dsp_byte_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        ack_err;
  logic        busy;
  logic [2:0]  owner;
  logic        sticky;
  logic        err_clear;
  logic [15:0] write_count;
  logic [1:0]  addr;
  logic        cs;
  logic        wn;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        fault;
  logic [7:0]  pio;

  logic [3:0]  req_h;
  logic [31:0] data_h;
  logic [3:0]  ack_h;
  logic        ack_err_h;
  logic        busy_h;
  logic [2:0]  owner_h;
  logic        sticky_h;
  logic        clr_h;
  logic [15:0] cnt_h;
  logic [1:0]  addr_h;
  logic        cs_h;
  logic        wn_h;
  logic [31:0] wd_h;
  logic [31:0] rd_h;
  logic [7:0]  pio_h;

  soc_system_dsp_byte_arbiter #(.NUM_REQ(4), .HOLD_CYCLES(0)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .ack(ack), .ack_err(ack_err), .busy(busy), .owner(owner),
    .err_sticky(sticky), .err_clear(err_clear),
    .write_count(write_count), .avm_address(addr),
    .avm_chipselect(cs), .avm_write_n(wn),
    .avm_writedata(wd), .avm_readdata(rd)
  );

  soc_system_dsp_byte_arbiter #(.NUM_REQ(4), .HOLD_CYCLES(5)) dut_h (
    .clk(clk), .reset(reset), .req(req_h), .req_data(data_h),
    .ack(ack_h), .ack_err(ack_err_h), .busy(busy_h), .owner(owner_h),
    .err_sticky(sticky_h), .err_clear(clr_h),
    .write_count(cnt_h), .avm_address(addr_h),
    .avm_chipselect(cs_h), .avm_write_n(wn_h),
    .avm_writedata(wd_h), .avm_readdata(rd_h)
  );

  always @(posedge clk) if (cs && !wn) pio <= wd[7:0];
  always @(posedge clk) if (cs_h && !wn_h) pio_h <= wd_h[7:0];
  assign rd   = fault ? 32'h0 : {24'h0, pio};
  assign rd_h = {24'h0, pio_h};

  int errs = 0;
  int checks = 0;
  int m_last;
  int m_cnt;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int rr_pick(input logic [3:0] r, input int last);
    for (int off = 1; off <= N; off++) begin
      if (((r >> ((last + off) % N)) & 4'd1) != 4'd0)
        return (last + off) % N;
    end
    return -1;
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] d, input int i);
    return 8'(d >> (8 * i));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0; req_data = '0; err_clear = 1'b0; fault = 1'b0;
    req_h = '0; data_h = '0; clr_h = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    m_last = N - 1;
    m_cnt = 0;
  endtask

  task automatic wait_ack(output int idx, output logic err, output int cyc);
    idx = -1; err = 1'b0; cyc = 0;
    while (idx == -1 && cyc < 40) begin
      step();
      cyc++;
      if (ack != 4'd0) begin
        err = ack_err;
        idx = -2;
        for (int i = 0; i < N; i++) if (ack == (4'b1 << i)) idx = i;
      end
    end
  endtask

  task automatic wait_ack_h(output int idx, output int cyc, output int lowb);
    idx = -1; cyc = 0; lowb = 0;
    while (idx == -1 && cyc < 40) begin
      step();
      cyc++;
      if (ack_h != 4'd0) begin
        idx = -2;
        for (int i = 0; i < N; i++) if (ack_h == (4'b1 << i)) idx = i;
      end else if (!busy_h) begin
        lowb++;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (ack !== 4'd0 || ack_err !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_ctl: ack=%b err=%b busy=%b want 0000 0 0",
               ack, ack_err, busy);
    end
    checks++;
    if (owner !== 3'd0 || sticky !== 1'b0 || write_count !== 16'd0) begin
      errs++;
      $display("FAIL reset_state: owner=%0d sticky=%b cnt=%h want 0 0 0",
               owner, sticky, write_count);
    end
    checks++;
    if (cs !== 1'b0 || wn !== 1'b1 || wd !== 32'd0 || addr !== 2'd0) begin
      errs++;
      $display("FAIL reset_bus: cs=%b wn=%b wd=%h addr=%0d want 0 1 0 0",
               cs, wn, wd, addr);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    req_data = 32'h00A5_0000;
    step();
    checks++;
    if (cs !== 1'b1 || wn !== 1'b0 || wd !== 32'h0000_00A5) begin
      errs++;
      $display("FAIL single_write: cs=%b wn=%b wd=%h want 1 0 000000a5",
               cs, wn, wd);
    end
    checks++;
    if (busy !== 1'b1 || owner !== 3'd2) begin
      errs++;
      $display("FAIL single_grant: busy=%b owner=%0d want 1 2", busy, owner);
    end
    step();
    checks++;
    if (cs !== 1'b1 || wn !== 1'b1 || pio !== 8'hA5) begin
      errs++;
      $display("FAIL single_verify: cs=%b wn=%b pio=%h want 1 1 a5",
               cs, wn, pio);
    end
    step();
    checks++;
    if (ack !== 4'b0100 || ack_err !== 1'b0 || write_count !== 16'd1) begin
      errs++;
      $display("FAIL single_ack: ack=%b err=%b cnt=%0d want 0100 0 1",
               ack, ack_err, write_count);
    end
    req = '0;
    m_last = 2;
    m_cnt = 1;
    step();
    checks++;
    if (ack !== 4'd0 || cs !== 1'b0 || wn !== 1'b1 || wd !== 32'd0 ||
        busy !== 1'b0) begin
      errs++;
      $display("FAIL single_idle: ack=%b cs=%b wn=%b wd=%h busy=%b",
               ack, cs, wn, wd, busy);
    end
  endtask

  task automatic test_round_robin();
    int idx, cyc, exp;
    logic err;
    logic [7:0] eb;
    do_reset();
    req = 4'b1111;
    req_data = 32'h1312_1110;
    for (int k = 0; k < 5; k++) begin
      exp = rr_pick(req, m_last);
      wait_ack(idx, err, cyc);
      checks++;
      if (idx !== exp || cyc !== ((k == 0) ? 3 : 4)) begin
        errs++;
        $display("FAIL rr_order%0d: idx=%0d cyc=%0d want %0d %0d",
                 k, idx, cyc, exp, (k == 0) ? 3 : 4);
      end
      checks++;
      if (pio !== byte_of(req_data, exp)) begin
        errs++;
        $display("FAIL rr_data%0d: pio=%h want %h",
                 k, pio, byte_of(req_data, exp));
      end
      m_last = exp;
      m_cnt++;
    end
    req = '0;
    step();
    for (int k = 0; k < 24; k++) begin
      logic [3:0]  r;
      logic [31:0] d;
      r = 4'($urandom_range(1, 15));
      d = $urandom;
      req = r;
      req_data = d;
      exp = rr_pick(r, m_last);
      eb = byte_of(d, exp);
      step();
      req_data = $urandom;
      req = 4'($urandom);
      wait_ack(idx, err, cyc);
      checks++;
      if (idx !== exp || cyc !== 2 || err !== 1'b0) begin
        errs++;
        $display("FAIL rand_ack%0d: idx=%0d cyc=%0d err=%b want %0d 2 0",
                 k, idx, cyc, err, exp);
      end
      m_cnt++;
      checks++;
      if (pio !== eb || write_count !== 16'(m_cnt)) begin
        errs++;
        $display("FAIL rand_data%0d: pio=%h cnt=%0d want %h %0d",
                 k, pio, write_count, eb, m_cnt);
      end
      m_last = exp;
      req = '0;
      step();
    end
  endtask

  task automatic test_fault();
    int idx, cyc;
    logic err;
    req = 4'b0010;
    req_data = 32'h0000_3C00;
    fault = 1'b1;
    wait_ack(idx, err, cyc);
    m_cnt++;
    checks++;
    if (idx !== 1 || err !== 1'b1 || sticky !== 1'b1) begin
      errs++;
      $display("FAIL fault_ack: idx=%0d err=%b sticky=%b want 1 1 1",
               idx, err, sticky);
    end
    checks++;
    if (pio !== 8'h3C || write_count !== 16'(m_cnt)) begin
      errs++;
      $display("FAIL fault_cnt: pio=%h cnt=%0d want 3c %0d",
               pio, write_count, m_cnt);
    end
    req = '0;
    m_last = 1;
    step();
    err_clear = 1'b1;
    req = 4'b0010;
    wait_ack(idx, err, cyc);
    m_cnt++;
    err_clear = 1'b0;
    req = '0;
    step();
    checks++;
    if (err !== 1'b1 || sticky !== 1'b1) begin
      errs++;
      $display("FAIL fault_setwins: err=%b sticky=%b want 1 1", err, sticky);
    end
    fault = 1'b0;
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    checks++;
    if (sticky !== 1'b0) begin
      errs++;
      $display("FAIL fault_clear: sticky=%b want 0", sticky);
    end
  endtask

  task automatic test_reset_mid();
    int idx, cyc;
    logic err;
    req = 4'b1000;
    req_data = 32'h5A00_0000;
    step();
    step();
    reset = 1'b1;
    #1;
    checks++;
    if (ack !== 4'd0 || busy !== 1'b0 || owner !== 3'd0 ||
        write_count !== 16'd0 || cs !== 1'b0 || wn !== 1'b1 ||
        wd !== 32'd0) begin
      errs++;
      $display("FAIL midrst_out: ack=%b busy=%b own=%0d cnt=%0d cs=%b wn=%b",
               ack, busy, owner, write_count, cs, wn);
    end
    step();
    checks++;
    if (ack !== 4'd0 || ack_err !== 1'b0) begin
      errs++;
      $display("FAIL midrst_noack: ack=%b err=%b want 0000 0", ack, ack_err);
    end
    reset = 1'b0;
    m_last = N - 1;
    m_cnt = 0;
    req = 4'b1001;
    req_data = 32'h7700_0066;
    wait_ack(idx, err, cyc);
    checks++;
    if (idx !== 0 || cyc !== 3 || pio !== 8'h66) begin
      errs++;
      $display("FAIL midrst_rr: idx=%0d cyc=%0d pio=%h want 0 3 66",
               idx, cyc, pio);
    end
    m_last = 0;
    m_cnt = 1;
    req = '0;
    step();
  endtask

  task automatic test_wrap();
    int idx, cyc;
    logic err;
    force dut.r_write_count = 16'hFFFF;
    step();
    release dut.r_write_count;
    step();
    checks++;
    if (write_count !== 16'hFFFF) begin
      errs++;
      $display("FAIL wrap_preload: cnt=%h want ffff", write_count);
    end
    req = 4'b0001;
    req_data = 32'h0000_00E1;
    wait_ack(idx, err, cyc);
    checks++;
    if (idx !== rr_pick(4'b0001, m_last) || write_count !== 16'h0000) begin
      errs++;
      $display("FAIL wrap_zero: idx=%0d cnt=%h want 0 0000",
               idx, write_count);
    end
    req = '0;
    step();
  endtask

  task automatic test_dwell();
    int idx, cyc, lowb, exp, ml;
    do_reset();
    ml = N - 1;
    req_h = 4'b0101;
    data_h = 32'h00C3_00B4;
    exp = rr_pick(req_h, ml);
    wait_ack_h(idx, cyc, lowb);
    checks++;
    if (idx !== exp || cyc !== 3) begin
      errs++;
      $display("FAIL dwell_first: idx=%0d cyc=%0d want %0d 3",
               idx, cyc, exp);
    end
    ml = exp;
    for (int k = 0; k < 3; k++) begin
      exp = rr_pick(req_h, ml);
      wait_ack_h(idx, cyc, lowb);
      checks++;
      if (idx !== exp || cyc !== 9 || lowb !== 1) begin
        errs++;
        $display("FAIL dwell%0d: idx=%0d gap=%0d idle=%0d want %0d 9 1",
                 k, idx, cyc, lowb, exp);
      end
      checks++;
      if (pio_h !== byte_of(data_h, exp)) begin
        errs++;
        $display("FAIL dwell_data%0d: pio=%h want %h",
                 k, pio_h, byte_of(data_h, exp));
      end
      ml = exp;
    end
    req_h = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_fault();
    test_reset_mid();
    test_wrap();
    test_dwell();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/soc_system_dsp_byte_arbiter.md
# soc_system_dsp_byte_arbiter

Round-robin arbiter and sequencer that shares the HPS-to-DSP byte output register between several on-fabric requesters. Each granted request becomes an Avalon-MM write of one byte to register offset 0 of the byte PIO, followed by a readback check. The block then enforces a configurable dwell time before the next update. It sits between the fabric requesters and the byte PIO slave port, alongside the HPS bridge path.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- HOLD_CYCLES, 0, extra idle cycles after each ack before the next grant (0..255)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-requester request level; held until the matching ack
- req_data  in  8*NUM_REQ  byte for requester i at bits [8i+7:8i]
- ack  out  NUM_REQ  one-cycle pulse to the granted requester when its transfer completes
- ack_err  out  1  valid with ack; 1 = readback mismatch
- busy  out  1  high in every state except IDLE
- owner  out  3  index of the current or last granted requester
- err_sticky  out  1  set on any mismatch
- err_clear  in  1  clears err_sticky
- write_count  out  16  completed transfers, wraps at 0xFFFF->0
- avm_address  out  2  always 0
- avm_chipselect  out  1  slave select
- avm_write_n  out  1  active-low write
- avm_writedata  out  32  {24'b0, latched byte}
- avm_readdata  in  32  PIO readdata (combinational in slave)

## Operation
- FSM states: IDLE, WRITE, VERIFY, ACK, HOLD.
- IDLE:
  - If any req bit is set, select a winner by round-robin, searching upward from (last_grant+1) mod NUM_REQ.
  - Latch that requester's req_data byte, update owner and last_grant, go to WRITE.
- WRITE: avm_chipselect=1, avm_write_n=0, avm_writedata={24'b0,byte}; go to VERIFY.
- VERIFY:
  - avm_chipselect=1, avm_write_n=1.
  - Compare avm_readdata[7:0] with the latched byte; only bits [7:0] are compared.
  - Register mismatch flag; go to ACK.
- ACK:
  - ack[owner]=1 and ack_err=mismatch.
  - write_count increments, including on error.
  - If mismatch, set err_sticky.
  - Go to HOLD if HOLD_CYCLES>0, else IDLE.
- HOLD: count HOLD_CYCLES cycles, then go to IDLE. No grant is made in HOLD.
- Request data is sampled only at grant. Changes to req_data after the grant are ignored for that transfer.
- A req that drops before it is granted is simply not served. A req that drops after grant does not abort the transfer; ack still pulses.
- Requesters must drop req, or present new data, in the cycle after ack. A req still high in IDLE is treated as a new request.
- err_clear and a mismatch set in the same cycle: set wins.
- Outside WRITE and VERIFY, all avm_* outputs are 0, except avm_write_n, which is 1.

## Timing
- Reset values:
  - state=IDLE, last_grant=NUM_REQ-1, so requester 0 has first priority.
  - ack=0, ack_err=0, busy=0, owner=0, err_sticky=0, write_count=0.
  - avm_chipselect=0, avm_write_n=1, avm_writedata=0, avm_address=0.
- Reset asserted mid-transfer: the FSM returns to IDLE immediately and no ack is issued. A PIO write already clocked in is not undone.
- All outputs are registered.
- Latency, with req seen in IDLE at cycle C0:
  - WRITE in C1; the PIO register updates at the end of C1.
  - VERIFY in C2, sampling the new value.
  - ack in C3.
  - Earliest next grant is in C4+HOLD_CYCLES.
- Throughput: one byte per 4+HOLD_CYCLES cycles.
- busy is high from C1 through the last HOLD cycle.

## Test plan
- Single request: reset, req[2]=1, data 0xA5 -> WRITE in C1 with writedata 0x000000A5; ack[2] in C3 with ack_err=0; PIO out_port=0xA5; write_count=1.
- Round robin: req=4'b1111 held, with bytes 0x10..0x13 -> grants in order 0,1,2,3,0; each ack spaced 4 cycles apart when HOLD_CYCLES=0.
- Dwell: HOLD_CYCLES=5, two requesters active -> acks spaced exactly 9 cycles apart; busy stays high through HOLD.
- Readback fault: the bench forces avm_readdata=0x00 in VERIFY for byte 0x3C -> ack_err=1 and err_sticky=1. Then err_clear pulsed in the same cycle as a second mismatch -> err_sticky stays 1.
- Reset mid-op: assert reset during VERIFY -> no ack issued, all outputs at reset values next cycle; after release, requester 0 wins a 4'b1001 contention.
- Counter wrap: preload 0xFFFF via forced transfers -> the next ack sets write_count to 0x0000.
